mskaes_rb_seq: RTL and testbench
================================

MSKAES_RB_SEQ -- requirements
Module: mskaes_rb_seq

Interface
REQ-001 SHALL have parameter d, default 2, number of Boolean shares (d>=2).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from rl_state_in to rl_state_out of the external masked round logic (>=1).
REQ-003 SHALL have parameter NR, default 10, rounds per block; legal values 10, 12, 14; other values SHALL fail elaboration.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  plaintext/key offered.
REQ-007 in_ready  out  1  block can accept.
REQ-008 sh_plaintext  in  128*d  shared plaintext.
REQ-009 sh_key  in  128*d  shared initial round key.
REQ-010 abort  in  1  discard current block.
REQ-011 rl_state_in  out  128*d  state to round logic.
REQ-012 rl_key_in  out  128*d  key to round logic.
REQ-013 rl_rcon  out  8  round constant, unshared.
REQ-014 rl_last  out  1  final round (no MixColumns).
REQ-015 rl_clean  out  1  round logic is being flushed.
REQ-016 rl_state_out, rl_key_out  in  128*d each  round logic results.
REQ-017 rnd_en  out  1  randomness buses must be fresh this cycle.
REQ-018 out_valid  out  1  ciphertext available.
REQ-019 out_ready  in  1  consumer accepts ciphertext.
REQ-020 sh_ciphertext  out  128*d  shared ciphertext.

Function
REQ-021 FSM states IDLE, RUN, HOLD, FLUSH; in_ready=1 only in IDLE.
REQ-022 Accept when in_valid&in_ready (cycle A): register sh_plaintext XOR sh_key share-wise as state, sh_key as key; go RUN.
REQ-023 Round r (1..NR) issued at cycle A+1+(r-1)*(LATENCY+1); rl_state_in/rl_key_in from internal registers, stable for the whole round.
REQ-024 rl_state_out/rl_key_out sampled exactly LATENCY cycles after issue, written to internal registers; no other cycle samples them.
REQ-025 rl_rcon: 0x01 in round 1, then xtime per round (shift left, XOR 0x1b on carry): 01,02,04,08,10,20,40,80,1b,36,6c,d8,ab,4d.
REQ-026 rl_last=1 during round NR issue window only.
REQ-027 Round NR result goes to output register; out_valid=1 at cycle A+1+NR*(LATENCY+1); state HOLD.
REQ-028 HOLD: out_valid and sh_ciphertext stable until out_valid&out_ready; then FLUSH.
REQ-029 sh_ciphertext SHALL be all-zero sharing whenever out_valid=0.
REQ-030 FLUSH: LATENCY+1 cycles, rl_state_in/rl_key_in all-zero sharing, rl_clean=1, internal state/key registers cleared; then IDLE.
REQ-031 rnd_en=1 in RUN and FLUSH, 0 otherwise.
REQ-032 abort=1 in RUN: next cycle enters FLUSH, no out_valid for that block; abort ignored in IDLE, HOLD, FLUSH.
REQ-033 in_valid in non-IDLE states SHALL be ignored; no input latched.
REQ-034 No unmasked recombination of shares anywhere; all share-wise ops per-share.

Reset
REQ-035 While rst=1: state IDLE, in_ready=1, out_valid=0, rl_clean=0, rnd_en=0, rl_last=0, rl_rcon=0x00, all share registers and sh_ciphertext zero.
REQ-036 rst asserted mid-RUN or HOLD SHALL drop the block immediately; first cycle after release is IDLE.

Verification
REQ-037 FIPS-197 vector, NR=10, LATENCY=4, d=2 random masks, key 000102..0f, pt 00112233..ff -> out_valid at A+51, recombined ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
REQ-038 out_ready held 0 for 20 cycles after out_valid -> ct stable, in_ready=0, then FLUSH 5 cycles with rl_clean=1, then in_ready=1.
REQ-039 abort at round 3 -> out_valid never rises, FLUSH LATENCY+1 cycles, next block yields correct ct.
REQ-040 NR=14, LATENCY=1 -> rl_rcon sequence 01..4d over rounds, rl_last only in round 14, out_valid at A+29.
REQ-041 rst pulse during round 5 -> all outputs reset values asynchronously; back-to-back blocks after release correct.
REQ-042 in_valid held high throughout -> exactly one acceptance per IDLE visit, sh_ciphertext zero whenever out_valid=0.

Source files
------------

// File: rtl/mskaes_rb_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mskaes_rb_seq_if : block handshake and round-logic bus of the sequencer    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mskaes_rb_seq_if #(
  parameter int d = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [128*d-1:0] sh_plaintext;
  logic [128*d-1:0] sh_key;
  logic             abort;
  logic [128*d-1:0] rl_state_in;
  logic [128*d-1:0] rl_key_in;
  logic [7:0]       rl_rcon;
  logic             rl_last;
  logic             rl_clean;
  logic [128*d-1:0] rl_state_out;
  logic [128*d-1:0] rl_key_out;
  logic             rnd_en;
  logic             out_valid;
  logic             out_ready;
  logic [128*d-1:0] sh_ciphertext;

  modport slave (
    input  in_valid, sh_plaintext, sh_key, abort, rl_state_out, rl_key_out, out_ready,
    output in_ready, rl_state_in, rl_key_in, rl_rcon, rl_last, rl_clean, rnd_en,
           out_valid, sh_ciphertext
  );

  modport master (
    output in_valid, sh_plaintext, sh_key, abort, rl_state_out, rl_key_out, out_ready,
    input  in_ready, rl_state_in, rl_key_in, rl_rcon, rl_last, rl_clean, rnd_en,
           out_valid, sh_ciphertext
  );
endinterface
`default_nettype wire

// File: rtl/mskaes_rb_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mskaes_rb_seq : round sequencer for an external masked AES round datapath |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mskaes_rb_seq #(
  parameter int d       = 2,
  parameter int LATENCY = 4,
  parameter int NR      = 10
) (
  input wire             clk,
  input wire             rst,
  mskaes_rb_seq_if.slave bus
);

  localparam int              c_w        = 128 * d;
  localparam int              c_cw       = $clog2(LATENCY + 1);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(LATENCY);
  localparam logic [3:0]      c_nr       = 4'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("mskaes_rb_seq: NR must be 10, 12 or 14");
  end
  if (d < 2) begin : g_bad_d
    $error("mskaes_rb_seq: d must be at least 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("mskaes_rb_seq: LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic [3:0]      round_q, round_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [c_w-1:0]  st_q, st_d;
  logic [c_w-1:0]  key_q, key_d;
  logic [c_w-1:0]  ct_q, ct_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      st_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      st_q    <= st_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    st_d    = st_q;
    key_d   = key_q;
    ct_d    = ct_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Initial AddRoundKey is a bitwise XOR, so it stays inside each share.
          st_d    = bus.sh_plaintext ^ bus.sh_key;
          key_d   = bus.sh_key;
          cnt_d   = '0;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          st_d    = '0;
          key_d   = '0;
          cnt_d   = '0;
          round_d = '0;
          rcon_d  = '0;
          state_d = S_FLUSH;
        end else if (cnt_q == c_cnt_last) begin
          // Round logic result is valid only on the last cycle of the round window.
          cnt_d = '0;
          if (round_q == c_nr) begin
            ct_d    = bus.rl_state_out;
            st_d    = '0;
            key_d   = '0;
            round_d = '0;
            rcon_d  = '0;
            state_d = S_HOLD;
          end else begin
            st_d    = bus.rl_state_out;
            key_d   = bus.rl_key_out;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end else begin
          cnt_d = cnt_q + c_cw'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          ct_d    = '0;
          cnt_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        st_d  = '0;
        key_d = '0;
        if (cnt_q == c_cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + c_cw'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Round-logic buses carry data only while a round is in flight; zeros otherwise flush it.
  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.rl_state_in   = (state_q == S_RUN) ? st_q : '0;
  assign bus.rl_key_in     = (state_q == S_RUN) ? key_q : '0;
  assign bus.rl_rcon       = (state_q == S_RUN) ? rcon_q : 8'h00;
  assign bus.rl_last       = (state_q == S_RUN) && (round_q == c_nr);
  assign bus.rl_clean      = (state_q == S_FLUSH);
  assign bus.rnd_en        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign bus.out_valid     = (state_q == S_HOLD);
  assign bus.sh_ciphertext = (state_q == S_HOLD) ? ct_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mskaes_rb_seq.sv
`default_nettype none
// Bench for mskaes_rb_seq: two sequencers (NR=10/LAT=4 and NR=14/LAT=1) driven by an
// emulated masked round datapath, results compared with a plain AES reference.
module tb_mskaes_rb_seq;

  localparam int D   = 2;
  localparam int LA  = 4;
  localparam int NRA = 10;
  localparam int LB  = 1;
  localparam int NRB = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sel;
  logic         in_valid;
  logic         abort;
  logic         out_ready;
  logic [255:0] pt_sh;
  logic [255:0] key_sh;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox [256];
  logic [7:0] rc_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                              8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  mskaes_rb_seq_if #(.d(D)) bus_a ();
  mskaes_rb_seq_if #(.d(D)) bus_b ();

  mskaes_rb_seq #(.d(D), .LATENCY(LA), .NR(NRA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mskaes_rb_seq #(.d(D), .LATENCY(LB), .NR(NRB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.in_valid     = in_valid & ~sel;
  assign bus_b.in_valid     = in_valid & sel;
  assign bus_a.abort        = abort & ~sel;
  assign bus_b.abort        = abort & sel;
  assign bus_a.sh_plaintext = pt_sh;
  assign bus_b.sh_plaintext = pt_sh;
  assign bus_a.sh_key       = key_sh;
  assign bus_b.sh_key       = key_sh;
  assign bus_a.out_ready    = out_ready;
  assign bus_b.out_ready    = out_ready;

  logic         o_in_ready, o_out_valid, o_rl_last, o_rl_clean, o_rnd_en;
  logic [7:0]   o_rl_rcon;
  logic [255:0] o_sh_ct, o_rl_state_in, o_rl_key_in;
  assign o_in_ready    = sel ? bus_b.in_ready      : bus_a.in_ready;
  assign o_out_valid   = sel ? bus_b.out_valid     : bus_a.out_valid;
  assign o_rl_last     = sel ? bus_b.rl_last       : bus_a.rl_last;
  assign o_rl_clean    = sel ? bus_b.rl_clean      : bus_a.rl_clean;
  assign o_rnd_en      = sel ? bus_b.rnd_en        : bus_a.rnd_en;
  assign o_rl_rcon     = sel ? bus_b.rl_rcon       : bus_a.rl_rcon;
  assign o_sh_ct       = sel ? bus_b.sh_ciphertext : bus_a.sh_ciphertext;
  assign o_rl_state_in = sel ? bus_b.rl_state_in   : bus_a.rl_state_in;
  assign o_rl_key_in   = sel ? bus_b.rl_key_in     : bus_a.rl_key_in;

  // ---------------- plain AES helpers (byte 0 at bits [127:120]) ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] w = {b, b};
    return w[15-n -: 8];
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
    return t;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] t = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      t[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      t[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      t[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      t[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return t;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] unshare(input logic [255:0] x);
    return x[255:128] ^ x[127:0];
  endfunction

  function automatic logic [255:0] share(input logic [127:0] v);
    logic [127:0] m = {$urandom(), $urandom(), $urandom(), $urandom()};
    return {v ^ m, m};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key, input int nr);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 1; r <= nr; r++) begin
      k = kexp(k, rc_tab[r-1]);
      s = sub_shift(s);
      if (r < nr) s = mix(s);
      s = s ^ k;
    end
    return s;
  endfunction

  // External masked round datapath: result of the inputs seen L cycles earlier, remasked.
  function automatic logic [511:0] round_fn(input logic [255:0] st, input logic [255:0] k,
                                            input logic [7:0] rc, input logic last);
    logic [127:0] kn = kexp(unshare(k), rc);
    logic [127:0] s  = sub_shift(unshare(st));
    if (!last) s = mix(s);
    s = s ^ kn;
    return {share(s), share(kn)};
  endfunction

  logic [511:0] pipe_a [LA];
  logic [511:0] pipe_b;
  always @(posedge clk) begin
    pipe_a[0] <= round_fn(bus_a.rl_state_in, bus_a.rl_key_in, bus_a.rl_rcon, bus_a.rl_last);
    for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= round_fn(bus_b.rl_state_in, bus_b.rl_key_in, bus_b.rl_rcon, bus_b.rl_last);
  end
  assign bus_a.rl_state_out = pipe_a[LA-1][511:256];
  assign bus_a.rl_key_out   = pipe_a[LA-1][255:0];
  assign bus_b.rl_state_out = pipe_b[511:256];
  assign bus_b.rl_key_out   = pipe_b[255:0];

  initial begin : sbox_build
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      v = 8'h01;
      for (int e = 0; e < 254; e++) v = gmul(v, x[7:0]);
      sbox[x] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  256'(o_in_ready),  256'd1);
    check({tag, "_out_valid"}, 256'(o_out_valid), 256'd0);
    check({tag, "_rl_clean"},  256'(o_rl_clean),  256'd0);
    check({tag, "_rnd_en"},    256'(o_rnd_en),    256'd0);
    check({tag, "_rl_last"},   256'(o_rl_last),   256'd0);
    check({tag, "_rl_rcon"},   256'(o_rl_rcon),   256'd0);
    check({tag, "_ct"},        o_sh_ct,           256'd0);
    check({tag, "_state_in"},  o_rl_state_in,     256'd0);
    check({tag, "_key_in"},    o_rl_key_in,       256'd0);
  endtask

  task automatic flush_phase(input int lat);
    int n = 0;
    bit bad = 0;
    while (o_rl_clean === 1'b1 && n < 64) begin
      if (o_rl_state_in !== '0 || o_rl_key_in !== '0 || o_out_valid !== 1'b0 ||
          o_sh_ct !== '0 || o_rnd_en !== 1'b1 || o_in_ready !== 1'b0 || o_rl_last !== 1'b0)
        bad = 1;
      @(negedge clk);
      n++;
    end
    check("flush_cycles", 256'(n), 256'(lat + 1));
    check("flush_outputs", 256'(bad), 256'd0);
    check("idle_after_flush", 256'(o_in_ready), 256'd1);
  endtask

  // mode 0: full block; 1: abort in round 3; 2: reset pulse in round 5
  task automatic do_block(input bit b, input logic [127:0] pt, input logic [127:0] key,
                          input int hold, input int mode, output logic [127:0] ct);
    int nr  = b ? NRB : NRA;
    int lat = b ? LB : LA;
    int k = 0;
    int w = 0;
    int r;
    bit seen = 0;
    bit bad = 0;
    logic [255:0] ct0;
    ct = '0;
    sel = b;
    pt_sh = share(pt);
    key_sh = share(key);
    in_valid = 1'b1;
    #1;
    while (o_in_ready !== 1'b1 && w < 100) begin
      @(negedge clk); #1; w++;
    end
    check("accept_ready", 256'(o_in_ready), 256'd1);
    @(posedge clk); #1;
    pt_sh = share(rand128());
    key_sh = share(rand128());
    while (k < 1 + nr*(lat+1) + 10 && !seen) begin
      @(negedge clk);
      k++;
      if (o_out_valid === 1'b1) begin
        seen = 1;
      end else begin
        r = (k - 1) / (lat + 1) + 1;
        if (r > 14) r = 14;
        if (o_rl_rcon !== rc_tab[r-1] || o_rl_last !== (r == nr) || o_rnd_en !== 1'b1 ||
            o_in_ready !== 1'b0 || o_sh_ct !== '0 || o_rl_clean !== 1'b0)
          bad = 1;
        if (mode == 1 && k == 1 + 2*(lat+1) + 1) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_round_seq", 256'(bad), 256'd0);
          check("abort_flush_entry", 256'(o_rl_clean), 256'd1);
          flush_phase(lat);
          return;
        end
        if (mode == 2 && k == 1 + 4*(lat+1) + 2) begin
          #2 rst = 1'b1;
          #1 check_reset("rst_mid");
          @(negedge clk);
          rst = 1'b0;
          #1 check("idle_after_rst", 256'(o_in_ready), 256'd1);
          return;
        end
      end
    end
    check("out_valid_latency", 256'(k), 256'(1 + nr*(lat+1)));
    check("round_seq", 256'(bad), 256'd0);
    ct0 = o_sh_ct;
    ct = unshare(ct0);
    check("ciphertext", 256'(ct), 256'(aes_ref(pt, key, nr)));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (o_sh_ct !== ct0 || o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_rnd_en !== 1'b0)
        bad = 1;
    end
    check("hold_stable", 256'(bad), 256'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("flush_entry", 256'(o_rl_clean), 256'd1);
    flush_phase(lat);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [127:0] ct;
    rst = 1'b1;
    sel = 1'b0;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    pt_sh = '0;
    key_sh = '0;
    repeat (3) @(negedge clk);
    #1 check_reset("rst_a");
    sel = 1'b1;
    #1 check_reset("rst_b");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_block(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             20, 0, ct);
    check("fips197_ct", 256'(ct), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    for (int i = 0; i < 3; i++)
      do_block(1'b0, rand128(), rand128(), int'($urandom_range(0, 3)), 0, ct);
    do_block(1'b0, rand128(), rand128(), 0, 1, ct);
    do_block(1'b0, rand128(), rand128(), 1, 0, ct);
    do_block(1'b0, rand128(), rand128(), 0, 2, ct);
    do_block(1'b0, rand128(), rand128(), 0, 0, ct);
    do_block(1'b0, rand128(), rand128(), 2, 0, ct);
    do_block(1'b1, rand128(), rand128(), 2, 0, ct);
    do_block(1'b1, rand128(), rand128(), 0, 1, ct);
    do_block(1'b1, rand128(), rand128(), 0, 0, ct);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
